mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers, alongside the single-cycle ALU in the EX stage.
- Accepts one op per start pulse from EX and sequences a fixed-latency busy window.
- Commits the result to HI/LO at the end of that window.
- Exposes busy so hazard control stalls later MD instructions; services MTHI/MTLO/MFHI/MFLO.

Parameters:
- MUL_LAT, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (legal range 1..15).
- DIV_LAT, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  single-cycle request; op, a and b are sampled on this edge.
- cancel  input  1  exception/flush in EX; start is suppressed this cycle.
- md_op  input  4  operation code:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu
  - 5 madd, 6 maddu, 7 msub, 8 msubu
  - 9 mthi, 10 mtlo
  - 11..15 none
- a  input  32  rs operand.
- b  input  32  rt operand.
- busy  output  1  registered; 1 while an op is in flight.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Reset (rst_n=0, async): busy=0, hi=0, lo=0, counter=0, pending result cleared, state IDLE. Reset mid-operation discards the op; HI/LO stay 0.
- Accept: accept = start & ~cancel & ~busy & (md_op in 1..10). Start while busy is ignored; the hazard unit guarantees this does not happen.
- States: IDLE, RUN.
- IDLE, accept with md_op 1..8:
  - Latch a, b, op.
  - Compute and hold the 64-bit result in a pending register; computing at accept is permitted.
  - counter <= LAT (MUL_LAT or DIV_LAT); busy <= 1; go to RUN.
- IDLE, accept with md_op 9/10: hi <= a or lo <= a at that edge. busy stays 0, state stays IDLE.
- RUN: each edge counter decrements. On the edge where counter==1:
  - {hi,lo} <= pending result.
  - busy <= 0; go to IDLE.
- Timing: start sampled at edge E0 gives busy=1 for LAT cycles after E0; new hi/lo and busy=0 are visible after edge E0+LAT.
- cancel has no effect in RUN; an issued op always completes.
- Arithmetic:
  - mult: signed 32x32->64.
  - multu: unsigned 32x32->64.
  - madd/maddu: {hi,lo} + product, mod 2^64.
  - msub/msubu: {hi,lo} - product, mod 2^64.
  - Accumulate ops use {hi,lo} as of the accept edge.
  - Result mapping: hi = bits[63:32], lo = bits[31:0].
- div/divu: lo = quotient, hi = remainder.
  - Signed div truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, no trap.
  - Divide by zero: the full DIV_LAT busy window still runs; hi/lo are left unchanged at commit.
- hi/lo outputs are direct register values; no bypass of pending results.

Test Plan:
- Reset: rst_n low mid-RUN (3 cycles into a div) -> busy, hi and lo all drop to 0 immediately, with no clock edge; no later commit.
- mult, a=0xFFFFFFFE, b=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div, a=0xFFFFFFF9 (-7), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu, a=7, b=0 with hi=0x11, lo=0x22 preset -> busy 10 cycles, then hi=0x11, lo=0x22.
- mthi 0x1 then mtlo 0x2 on consecutive cycles (busy stays 0), then madd a=3, b=4 -> hi=0x1, lo=0xE. Then msubu a=0xF, b=1 -> lo=0xFFFFFFFF, hi=0x0.
- start with cancel=1 -> no busy and HI/LO unchanged. start with md_op=12 -> ignored. start during busy with mult 2x2 -> ignored; the first op's result is committed unaltered.
- Back-to-back: mult commits, and a new start on the commit cycle is ignored (busy still 1). Start on the next cycle -> accepted; that accumulate-free op's result overwrites HI/LO after MUL_LAT.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// EX <-> multiply/divide unit request bus and HI/LO read-back.
// Master is the EX stage; slave is mdu_ctrl.
interface mdu_ctrl_if;
    logic        start;
    logic        cancel;
    logic [3:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, cancel, md_op, a, b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, cancel, md_op, a, b,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Result is computed at accept and committed after a fixed busy window.
module mdu_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input logic     clk,
    input logic     rst_n,
    mdu_ctrl_if.slave md
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [63:0] pend;
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_md;
    logic        is_mt;
    logic        accept;
    logic [3:0]  lat;
    logic [63:0] hl;
    logic [63:0] ps;
    logic [63:0] pu;
    logic        dz;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] dv;
    logic [31:0] dvu;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [63:0] res;

    assign md.busy = busy_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

    always_comb begin
        is_md  = (md.md_op >= 4'd1) && (md.md_op <= 4'd8);
        is_mt  = (md.md_op == 4'd9) || (md.md_op == 4'd10);
        accept = md.start & ~md.cancel & ~busy_q & (is_md | is_mt);
        lat    = (md.md_op == 4'd3 || md.md_op == 4'd4) ?
                 DIV_LAT[3:0] : MUL_LAT[3:0];
        hl     = {hi_q, lo_q};
        // Low 64 bits of the sign-extended product equal the signed product.
        ps     = {{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b};
        pu     = {32'd0, md.a} * {32'd0, md.b};
        dz     = (md.b == 32'd0);
        ua     = md.a[31] ? (32'd0 - md.a) : md.a;
        ub     = md.b[31] ? (32'd0 - md.b) : md.b;
        dv     = dz ? 32'd1 : ub;
        dvu    = dz ? 32'd1 : md.b;
        // Magnitude divide keeps 0x80000000 / -1 well defined.
        uq     = ua / dv;
        ur     = ua % dv;
        sq     = (md.a[31] ^ md.b[31]) ? (32'd0 - uq) : uq;
        sr     = md.a[31] ? (32'd0 - ur) : ur;
        res    = hl;
        case (md.md_op)
            4'd1:    res = ps;
            4'd2:    res = pu;
            4'd3:    res = dz ? hl : {sr, sq};
            4'd4:    res = dz ? hl : {md.a % dvu, md.a / dvu};
            4'd5:    res = hl + ps;
            4'd6:    res = hl + pu;
            4'd7:    res = hl - ps;
            4'd8:    res = hl - pu;
            default: res = hl;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            pend   <= 64'd0;
            busy_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_mt) begin
                        if (md.md_op == 4'd9) hi_q <= md.a;
                        else                  lo_q <= md.a;
                    end else if (accept) begin
                        pend   <= res;
                        cnt    <= lat;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        {hi_q, lo_q} <= pend;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl against an arithmetic HI/LO model.
// Directed scenarios from the plan plus a randomized op stream.
module tb_mdu_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    mdu_ctrl_if md ();

    mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .md   (md.slave)
    );

    always #5 clk = ~clk;

    int          pass_cnt = 0;
    int          tot_cnt  = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    function automatic int exp_lat(input logic [3:0] op);
        if (op == 4'd3 || op == 4'd4) return 10;
        if (op >= 4'd1 && op <= 4'd8) return 5;
        return 0;
    endfunction

    task automatic model(input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y);
        logic [63:0] hl, ps, pu;
        longint sx, sy, q, r;
        hl = {m_hi, m_lo};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ps = sx * sy;
        pu = {32'd0, x} * {32'd0, y};
        case (op)
            4'd1: hl = ps;
            4'd2: hl = pu;
            4'd3: if (y != 0) begin
                q = sx / sy;
                r = sx % sy;
                hl = {r[31:0], q[31:0]};
            end
            4'd4: if (y != 0) hl = {x % y, x / y};
            4'd5: hl = hl + ps;
            4'd6: hl = hl + pu;
            4'd7: hl = hl - ps;
            4'd8: hl = hl - pu;
            4'd9: hl[63:32] = x;
            4'd10: hl[31:0] = x;
            default: ;
        endcase
        {m_hi, m_lo} = hl;
    endtask

    task automatic pulse(input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic cn);
        @(negedge clk);
        md.start = 1'b1;
        md.cancel = cn;
        md.md_op = op;
        md.a = x;
        md.b = y;
        @(posedge clk);
        #1;
        md.start = 1'b0;
        md.cancel = 1'b0;
        md.md_op = 4'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (md.busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, output int n);
        pulse(op, x, y, 1'b0);
        wait_idle(n);
        model(op, x, y);
    endtask

    task automatic test_reset();
        int n;
        md.start = 1'b0;
        md.cancel = 1'b0;
        md.md_op = 4'd0;
        md.a = 32'd0;
        md.b = 32'd0;
        #12;
        tot_cnt++;
        if ({md.busy, md.hi, md.lo} !== 65'd0)
            $display("FAIL reset_init got %b/%h/%h want 0/0/0",
                     md.busy, md.hi, md.lo);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        pulse(4'd9, 32'h55, 32'd0, 1'b0);
        pulse(4'd3, 32'd100, 32'd7, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tot_cnt++;
        if (md.busy !== 1'b0)
            $display("FAIL reset_async_busy got %b want 0", md.busy);
        else pass_cnt++;
        tot_cnt++;
        if ({md.hi, md.lo} !== 64'd0)
            $display("FAIL reset_async_hilo got %h/%h want 0/0",
                     md.hi, md.lo);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        tot_cnt++;
        if ({md.busy, md.hi, md.lo} !== 65'd0)
            $display("FAIL reset_no_commit got %b/%h/%h want 0/0/0",
                     md.busy, md.hi, md.lo);
        else pass_cnt++;
        m_hi = 32'd0;
        m_lo = 32'd0;
        n = 0;
    endtask

    task automatic test_mult();
        int n;
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, n);
        tot_cnt++;
        if (n !== 5) $display("FAIL mult_lat got %0d want 5", n);
        else pass_cnt++;
        tot_cnt++;
        if ({md.hi, md.lo} !== {m_hi, m_lo} ||
            {m_hi, m_lo} !== 64'hFFFFFFFF_FFFFFFFA)
            $display("FAIL mult got %h/%h want %h/%h", md.hi, md.lo,
                     m_hi, m_lo);
        else pass_cnt++;
        run_op(4'd2, 32'hFFFFFFFE, 32'd3, n);
        tot_cnt++;
        if ({md.hi, md.lo} !== {m_hi, m_lo} ||
            {m_hi, m_lo} !== 64'h00000002_FFFFFFFA)
            $display("FAIL multu got %h/%h want %h/%h", md.hi, md.lo,
                     m_hi, m_lo);
        else pass_cnt++;
    endtask

    task automatic test_div();
        int n;
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, n);
        tot_cnt++;
        if (n !== 10) $display("FAIL div_lat got %0d want 10", n);
        else pass_cnt++;
        tot_cnt++;
        if ({md.hi, md.lo} !== {m_hi, m_lo} ||
            {m_hi, m_lo} !== 64'hFFFFFFFF_FFFFFFFD)
            $display("FAIL div got %h/%h want %h/%h", md.hi, md.lo,
                     m_hi, m_lo);
        else pass_cnt++;
        run_op(4'd9, 32'h11, 32'd0, n);
        run_op(4'd10, 32'h22, 32'd0, n);
        run_op(4'd4, 32'd7, 32'd0, n);
        tot_cnt++;
        if (n !== 10) $display("FAIL divz_lat got %0d want 10", n);
        else pass_cnt++;
        tot_cnt++;
        if ({md.hi, md.lo} !== {m_hi, m_lo} ||
            {m_hi, m_lo} !== 64'h00000011_00000022)
            $display("FAIL divz got %h/%h want %h/%h", md.hi, md.lo,
                     m_hi, m_lo);
        else pass_cnt++;
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
        tot_cnt++;
        if ({md.hi, md.lo} !== {m_hi, m_lo} ||
            {m_hi, m_lo} !== 64'h00000000_80000000)
            $display("FAIL div_ovf got %h/%h want %h/%h", md.hi, md.lo,
                     m_hi, m_lo);
        else pass_cnt++;
    endtask

    task automatic test_acc();
        int n;
        run_op(4'd9, 32'h1, 32'd0, n);
        tot_cnt++;
        if (n !== 0) $display("FAIL mthi_busy got %0d want 0", n);
        else pass_cnt++;
        run_op(4'd10, 32'h2, 32'd0, n);
        tot_cnt++;
        if ({md.hi, md.lo} !== 64'h00000001_00000002)
            $display("FAIL mthi_mtlo got %h/%h want 1/2", md.hi, md.lo);
        else pass_cnt++;
        run_op(4'd5, 32'd3, 32'd4, n);
        tot_cnt++;
        if ({md.hi, md.lo} !== {m_hi, m_lo} ||
            {m_hi, m_lo} !== 64'h00000001_0000000E)
            $display("FAIL madd got %h/%h want %h/%h", md.hi, md.lo,
                     m_hi, m_lo);
        else pass_cnt++;
        run_op(4'd8, 32'hF, 32'd1, n);
        tot_cnt++;
        if ({md.hi, md.lo} !== {m_hi, m_lo} ||
            {m_hi, m_lo} !== 64'h00000000_FFFFFFFF)
            $display("FAIL msubu got %h/%h want %h/%h", md.hi, md.lo,
                     m_hi, m_lo);
        else pass_cnt++;
    endtask

    task automatic test_ignore();
        int n;
        pulse(4'd1, 32'd9, 32'd9, 1'b1);
        tot_cnt++;
        if ({md.busy, md.hi, md.lo} !== {1'b0, m_hi, m_lo})
            $display("FAIL cancel got %b/%h/%h want 0/%h/%h",
                     md.busy, md.hi, md.lo, m_hi, m_lo);
        else pass_cnt++;
        pulse(4'd12, 32'd9, 32'd9, 1'b0);
        tot_cnt++;
        if ({md.busy, md.hi, md.lo} !== {1'b0, m_hi, m_lo})
            $display("FAIL bad_op got %b/%h/%h want 0/%h/%h",
                     md.busy, md.hi, md.lo, m_hi, m_lo);
        else pass_cnt++;
        pulse(4'd1, 32'd3, 32'd5, 1'b0);
        model(4'd1, 32'd3, 32'd5);
        repeat (2) @(posedge clk);
        pulse(4'd1, 32'd2, 32'd2, 1'b0);
        wait_idle(n);
        tot_cnt++;
        if (n !== 2) $display("FAIL busy_start_lat got %0d want 2", n);
        else pass_cnt++;
        tot_cnt++;
        if ({md.hi, md.lo} !== {m_hi, m_lo})
            $display("FAIL busy_start got %h/%h want %h/%h", md.hi, md.lo,
                     m_hi, m_lo);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n;
        pulse(4'd1, 32'd6, 32'd7, 1'b0);
        model(4'd1, 32'd6, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        tot_cnt++;
        if (md.busy !== 1'b1)
            $display("FAIL b2b_busy got %b want 1", md.busy);
        else pass_cnt++;
        md.start = 1'b1;
        md.md_op = 4'd2;
        md.a = 32'd100;
        md.b = 32'd100;
        @(posedge clk);
        #1;
        md.start = 1'b0;
        md.md_op = 4'd0;
        tot_cnt++;
        if ({md.busy, md.hi, md.lo} !== {1'b0, m_hi, m_lo})
            $display("FAIL b2b_commit got %b/%h/%h want 0/%h/%h",
                     md.busy, md.hi, md.lo, m_hi, m_lo);
        else pass_cnt++;
        run_op(4'd2, 32'h12345678, 32'h9ABCDEF0, n);
        tot_cnt++;
        if (n !== 5 || {md.hi, md.lo} !== {m_hi, m_lo})
            $display("FAIL b2b_next got %0d:%h/%h want 5:%h/%h", n,
                     md.hi, md.lo, m_hi, m_lo);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int n;
        logic [3:0]  op;
        logic [31:0] x, y;
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(1, 10));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 7) == 0) y = 32'd0;
            if ($urandom_range(0, 7) == 0) y = 32'($urandom_range(1, 9));
            if (i == 7) begin
                op = 4'd3;
                x = 32'h80000000;
                y = 32'hFFFFFFFF;
            end
            run_op(op, x, y, n);
            tot_cnt++;
            if (n !== exp_lat(op) || {md.hi, md.lo} !== {m_hi, m_lo})
                $display("FAIL rand%0d op%0d got %0d:%h/%h want %0d:%h/%h",
                         i, op, n, md.hi, md.lo, exp_lat(op), m_hi, m_lo);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_acc();
        test_ignore();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
